// File: rtl/speicher_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state encoding and port-select constants.
package speicher_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INSTR      = 3'd1,
    DLESEN     = 3'd2,
    DSCHREIBEN = 3'd3,
    ERLEDIGT   = 3'd4
  } zustand_t;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATEN = 1'b1;

endpackage

// File: rtl/speicher_auswahl.sv
// Combinational grant select: picks the next FSM state and the granted port
// from the three pending requests and the last-granted pointer.
module speicher_auswahl
  import speicher_arbiter_pkg::*;
(
  input  logic     i_lese_instr,
  input  logic     i_lese_daten,
  input  logic     i_schreibe_daten,
  input  logic     i_zeiger,
  output zustand_t o_zustand,
  output logic     o_port
);

  logic w_daten_anfrage;
  logic w_daten_gewinnt;

  assign w_daten_anfrage = i_lese_daten | i_schreibe_daten;
  // On a tie the data port wins unless it was the one granted last
  assign w_daten_gewinnt = w_daten_anfrage & (~i_lese_instr | (i_zeiger == PORT_INSTR));

  // Grant decision; a write beats a simultaneous data read
  always_comb begin
    o_zustand = IDLE;
    o_port    = PORT_INSTR;
    if (w_daten_gewinnt) begin
      o_port    = PORT_DATEN;
      o_zustand = i_schreibe_daten ? DSCHREIBEN : DLESEN;
    end else if (i_lese_instr) begin
      o_port    = PORT_INSTR;
      o_zustand = INSTR;
    end else begin
      o_port    = PORT_INSTR;
      o_zustand = IDLE;
    end
  end

endmodule

// File: rtl/speicher_arbiter.sv
// Shares one RAM between the CPU fetch and data ports, one access at a time.
// Optional macro SPEICHER_ROUND_ROBIN_EN: alternate grants on ties instead of data-first.
module speicher_arbiter
  import speicher_arbiter_pkg::*;
#(
  parameter int ADRESSBREITE = 32,
  parameter int WORTBREITE   = 32
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    LeseInstruktion,
  input  logic [ADRESSBREITE-1:0] InstruktionAdresse,
  output logic [WORTBREITE-1:0]   Instruktion,
  output logic                    InstruktionGeladen,
  input  logic                    LeseDaten,
  input  logic                    SchreibeDaten,
  input  logic [ADRESSBREITE-1:0] DatenAdresse,
  input  logic [WORTBREITE-1:0]   DatenRaus,
  output logic [WORTBREITE-1:0]   DatenRein,
  output logic                    DatenGeladen,
  output logic                    DatenGespeichert,
  output logic                    RamLesenAn,
  output logic                    RamSchreibenAn,
  output logic [ADRESSBREITE-1:0] RamAdresse,
  output logic [WORTBREITE-1:0]   RamDatenRein,
  input  logic [WORTBREITE-1:0]   RamDatenRaus,
  input  logic                    RamDatenBereit,
  input  logic                    RamDatenGeschrieben
);

  zustand_t r_zustand;
  zustand_t w_naechster;
  zustand_t w_auswahl_zustand;
  logic     w_auswahl_port;
  logic     w_zeiger;

  logic                    r_ram_lesen,      w_ram_lesen;
  logic                    r_ram_schreiben,  w_ram_schreiben;
  logic [ADRESSBREITE-1:0] r_ram_adresse,    w_ram_adresse;
  logic [WORTBREITE-1:0]   r_ram_daten,      w_ram_daten;
  logic [WORTBREITE-1:0]   r_instruktion,    w_instruktion;
  logic [WORTBREITE-1:0]   r_daten_rein,     w_daten_rein;
  logic                    r_instr_geladen,  w_instr_geladen;
  logic                    r_daten_geladen,  w_daten_geladen;
  logic                    r_daten_gespeichert, w_daten_gespeichert;

  speicher_auswahl u_auswahl (
    .i_lese_instr     (LeseInstruktion),
    .i_lese_daten     (LeseDaten),
    .i_schreibe_daten (SchreibeDaten),
    .i_zeiger         (w_zeiger),
    .o_zustand        (w_auswahl_zustand),
    .o_port           (w_auswahl_port)
  );

`ifdef SPEICHER_ROUND_ROBIN_EN
  logic r_zeiger;

  // Remember which port received the most recent grant
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_zeiger <= PORT_INSTR;
    end else if ((r_zustand == IDLE) && (w_auswahl_zustand != IDLE)) begin
      r_zeiger <= w_auswahl_port;
    end else begin
      r_zeiger <= r_zeiger;
    end
  end

  assign w_zeiger = r_zeiger;
`else
  assign w_zeiger = PORT_INSTR;
`endif

  // State register plus every output register; reset abandons any access
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_zustand           <= IDLE;
      r_ram_lesen         <= 1'b0;
      r_ram_schreiben     <= 1'b0;
      r_ram_adresse       <= {ADRESSBREITE{1'b0}};
      r_ram_daten         <= {WORTBREITE{1'b0}};
      r_instruktion       <= {WORTBREITE{1'b0}};
      r_daten_rein        <= {WORTBREITE{1'b0}};
      r_instr_geladen     <= 1'b0;
      r_daten_geladen     <= 1'b0;
      r_daten_gespeichert <= 1'b0;
    end else begin
      r_zustand           <= w_naechster;
      r_ram_lesen         <= w_ram_lesen;
      r_ram_schreiben     <= w_ram_schreiben;
      r_ram_adresse       <= w_ram_adresse;
      r_ram_daten         <= w_ram_daten;
      r_instruktion       <= w_instruktion;
      r_daten_rein        <= w_daten_rein;
      r_instr_geladen     <= w_instr_geladen;
      r_daten_geladen     <= w_daten_geladen;
      r_daten_gespeichert <= w_daten_gespeichert;
    end
  end

  // Next-state logic; completions only count in their matching state
  always_comb begin
    w_naechster = r_zustand;
    case (r_zustand)
      IDLE:       w_naechster = w_auswahl_zustand;
      INSTR:      w_naechster = RamDatenBereit      ? ERLEDIGT : INSTR;
      DLESEN:     w_naechster = RamDatenBereit      ? ERLEDIGT : DLESEN;
      DSCHREIBEN: w_naechster = RamDatenGeschrieben ? ERLEDIGT : DSCHREIBEN;
      ERLEDIGT:   w_naechster = IDLE;
      default:    w_naechster = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_ram_lesen         = 1'b0;
    w_ram_schreiben     = 1'b0;
    w_ram_adresse       = r_ram_adresse;
    w_ram_daten         = r_ram_daten;
    w_instruktion       = r_instruktion;
    w_daten_rein        = r_daten_rein;
    w_instr_geladen     = 1'b0;
    w_daten_geladen     = 1'b0;
    w_daten_gespeichert = 1'b0;
    case (r_zustand)
      IDLE: begin
        if (w_auswahl_zustand != IDLE) begin
          w_ram_adresse   = (w_auswahl_port == PORT_DATEN) ? DatenAdresse : InstruktionAdresse;
          w_ram_lesen     = (w_auswahl_zustand == INSTR) || (w_auswahl_zustand == DLESEN);
          w_ram_schreiben = (w_auswahl_zustand == DSCHREIBEN);
          if (w_auswahl_zustand == DSCHREIBEN) begin
            w_ram_daten = DatenRaus;
          end else begin
            w_ram_daten = r_ram_daten;
          end
        end else begin
          w_ram_adresse = r_ram_adresse;
        end
      end
      INSTR: begin
        if (RamDatenBereit) begin
          w_instruktion   = RamDatenRaus;
          w_instr_geladen = 1'b1;
        end else begin
          w_ram_lesen = 1'b1;
        end
      end
      DLESEN: begin
        if (RamDatenBereit) begin
          w_daten_rein    = RamDatenRaus;
          w_daten_geladen = 1'b1;
        end else begin
          w_ram_lesen = 1'b1;
        end
      end
      DSCHREIBEN: begin
        if (RamDatenGeschrieben) begin
          w_daten_gespeichert = 1'b1;
        end else begin
          w_ram_schreiben = 1'b1;
        end
      end
      ERLEDIGT: begin
        w_ram_lesen     = 1'b0;
        w_ram_schreiben = 1'b0;
      end
      default: begin
        w_ram_lesen     = 1'b0;
        w_ram_schreiben = 1'b0;
      end
    endcase
  end

  assign Instruktion        = r_instruktion;
  assign InstruktionGeladen = r_instr_geladen;
  assign DatenRein          = r_daten_rein;
  assign DatenGeladen       = r_daten_geladen;
  assign DatenGespeichert   = r_daten_gespeichert;
  assign RamLesenAn         = r_ram_lesen;
  assign RamSchreibenAn     = r_ram_schreiben;
  assign RamAdresse         = r_ram_adresse;
  assign RamDatenRein       = r_ram_daten;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Bench for speicher_arbiter: RAM model with variable latency, two requester
// processes, and a scoreboard monitor checking every done pulse.
module tb_speicher_arbiter;

  typedef struct packed {
    logic        wr;
    logic [31:0] d;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        LeseInstruktion = 1'b0;
  logic [31:0] InstruktionAdresse = 32'h0;
  logic [31:0] Instruktion;
  logic        InstruktionGeladen;
  logic        LeseDaten = 1'b0;
  logic        SchreibeDaten = 1'b0;
  logic [31:0] DatenAdresse = 32'h0;
  logic [31:0] DatenRaus = 32'h0;
  logic [31:0] DatenRein;
  logic        DatenGeladen;
  logic        DatenGespeichert;
  logic        RamLesenAn;
  logic        RamSchreibenAn;
  logic [31:0] RamAdresse;
  logic [31:0] RamDatenRein;
  logic [31:0] RamDatenRaus = 32'h0;
  logic        RamDatenBereit;
  logic        RamDatenGeschrieben;

  speicher_arbiter dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .LeseInstruktion    (LeseInstruktion),
    .InstruktionAdresse (InstruktionAdresse),
    .Instruktion        (Instruktion),
    .InstruktionGeladen (InstruktionGeladen),
    .LeseDaten          (LeseDaten),
    .SchreibeDaten      (SchreibeDaten),
    .DatenAdresse       (DatenAdresse),
    .DatenRaus          (DatenRaus),
    .DatenRein          (DatenRein),
    .DatenGeladen       (DatenGeladen),
    .DatenGespeichert   (DatenGespeichert),
    .RamLesenAn         (RamLesenAn),
    .RamSchreibenAn     (RamSchreibenAn),
    .RamAdresse         (RamAdresse),
    .RamDatenRein       (RamDatenRein),
    .RamDatenRaus       (RamDatenRaus),
    .RamDatenBereit     (RamDatenBereit),
    .RamDatenGeschrieben(RamDatenGeschrieben)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [0:63];
  logic [31:0] q_instr [$];
  exp_t        q_daten [$];
  int          done_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // RAM model: completes lat cycles after it first sees a strobe
  logic [31:0] ram [0:63];
  int   ram_cnt = 0, ram_lat = 1, ram_last_lat = 1, lat_fixed = 1;
  bit   ram_hold = 1'b0;
  logic ram_rdy = 1'b0, ram_wr_done = 1'b0, inj_rdy = 1'b0;
  assign RamDatenBereit      = ram_rdy | inj_rdy;
  assign RamDatenGeschrieben = ram_wr_done;

  always @(posedge Clock) begin
    ram_rdy     <= 1'b0;
    ram_wr_done <= 1'b0;
    if (!(RamLesenAn || RamSchreibenAn)) begin
      ram_cnt <= 0;
      ram_lat <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(3, 1));
    end else begin
      ram_cnt <= ram_cnt + 1;
      if ((ram_cnt + 1 == ram_lat) && !ram_hold) begin
        ram_last_lat <= ram_lat;
        if (RamSchreibenAn) begin
          ram[RamAdresse[5:0]] <= RamDatenRein;
          ram_wr_done <= 1'b1;
        end else begin
          RamDatenRaus <= ram[RamAdresse[5:0]];
          ram_rdy <= 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor
  int   strobe_len = 0;
  exp_t e_mon;
  always @(negedge Clock) begin
    if (Reset) begin
      strobe_len = 0;
    end else begin
      chk("strobes_exclusive", {31'b0, RamLesenAn & RamSchreibenAn}, 32'h0);
      if (RamLesenAn | RamSchreibenAn) strobe_len++;
      chk("done_exclusive",
          {31'b0, (int'(InstruktionGeladen) + int'(DatenGeladen) + int'(DatenGespeichert)) <= 1}, 32'h1);
      if (InstruktionGeladen | DatenGeladen | DatenGespeichert) begin
        chk("strobe_cycles", strobe_len, ram_last_lat + 1);
        strobe_len = 0;
      end
      if (InstruktionGeladen) begin
        done_log.push_back(0);
        if (q_instr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_instr_done: got pulse expected none");
        end else begin
          chk("instruktion", Instruktion, q_instr.pop_front());
        end
      end
      if (DatenGeladen | DatenGespeichert) begin
        done_log.push_back(1);
        if (q_daten.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_data_done: got pulse expected none");
        end else begin
          e_mon = q_daten.pop_front();
          chk("daten_kind_write", {31'b0, DatenGespeichert}, {31'b0, e_mon.wr});
          if (!e_mon.wr) chk("daten_rein", DatenRein, e_mon.d);
        end
      end
    end
  end

  task automatic instr_req(input logic [31:0] a, input bit keep, output int cyc);
    bit got;
    q_instr.push_back(model_mem[a[5:0]]);
    LeseInstruktion = 1'b1;
    InstruktionAdresse = a;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge Clock); cyc++;
      @(negedge Clock);
      if (InstruktionGeladen) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL instr_timeout: got no pulse expected InstruktionGeladen");
    end
    @(posedge Clock); #1;
    if (!keep) LeseInstruktion = 1'b0;
  endtask

  task automatic data_req(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input bit keep);
    exp_t e;
    bit   got;
    if (wr) begin
      model_mem[a[5:0]] = d;
      e.wr = 1'b1; e.d = d;
    end else begin
      e.wr = 1'b0; e.d = model_mem[a[5:0]];
    end
    q_daten.push_back(e);
    SchreibeDaten = wr; LeseDaten = rd; DatenAdresse = a; DatenRaus = d;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge Clock);
      if (DatenGeladen | DatenGespeichert) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL data_timeout: got no pulse expected data done");
    end
    @(posedge Clock); #1;
    if (!keep) begin
      SchreibeDaten = 1'b0; LeseDaten = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {27'b0, RamLesenAn, RamSchreibenAn, InstruktionGeladen,
                          DatenGeladen, DatenGespeichert}, 32'h0);
    chk({tag, "_ram_adresse"}, RamAdresse, 32'h0);
    chk({tag, "_ram_daten"}, RamDatenRein, 32'h0);
    chk({tag, "_instruktion"}, Instruktion, 32'h0);
    chk({tag, "_daten_rein"}, DatenRein, 32'h0);
  endtask

  task automatic check_order(input string tag, input int exp_q [$]);
    chk({tag, "_count"}, done_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < done_log.size(); i++)
      chk({tag, "_port"}, done_log[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  int  c_i, c_d, g_i, g_d, op, cyc;
  bit  got;
  int  exp_ord [$];

  initial begin
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = $urandom;
      ram[i] <= model_mem[i];
    end
    model_mem[5] = 32'h8040000F;
    ram[5] <= 32'h8040000F;

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_zero("reset");
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Lone fetch, RAM latency 1
    lat_fixed = 1;
    instr_req(32'd5, 1'b0, cyc);
    chk("fetch_cycles", cyc, 3);
    chk("fetch_word", Instruktion, 32'h8040000F);

    // Write then read back
    data_req(1'b1, 1'b0, 32'd7, 32'hDEADBEEF, 1'b0);
    data_req(1'b0, 1'b1, 32'd7, 32'h0, 1'b0);
    chk("readback", DatenRein, 32'hDEADBEEF);

    // Read and write together: only the write happens
    data_req(1'b1, 1'b1, 32'd3, 32'h12345678, 1'b0);
    data_req(1'b0, 1'b1, 32'd3, 32'h0, 1'b0);
    chk("illegal_rw_readback", DatenRein, 32'h12345678);

    // Reset while the RAM is still busy
    ram_hold = 1'b1;
    LeseInstruktion = 1'b1; InstruktionAdresse = 32'd9;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clock);
      if (RamLesenAn) got = 1'b1;
    end
    chk("abort_strobe_seen", {31'b0, got}, 32'h1);
    @(posedge Clock); #1;
    Reset = 1'b1; LeseInstruktion = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check_zero("abort");
    @(posedge Clock); #1;
    Reset = 1'b0; ram_hold = 1'b0;
    @(posedge Clock); #1;
    inj_rdy = 1'b1;
    @(posedge Clock); #1;
    inj_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk("late_ready_ignored", {27'b0, RamLesenAn, RamSchreibenAn, InstruktionGeladen,
                                 DatenGeladen, DatenGespeichert}, 32'h0);
    end
    @(posedge Clock); #1;

    // Simultaneous fetch and data read: data first after reset
    done_log.delete();
    fork
      instr_req(32'd10, 1'b0, c_i);
      data_req(1'b0, 1'b1, 32'd40, 32'h0, 1'b0);
    join
    exp_ord = '{1, 0};
    check_order("tie", exp_ord);

    // Both ports held continuously for two accesses each
    done_log.delete();
    fork
      begin
        instr_req(32'd11, 1'b1, c_i);
        instr_req(32'd12, 1'b0, c_i);
      end
      begin
        data_req(1'b0, 1'b1, 32'd41, 32'h0, 1'b1);
        data_req(1'b0, 1'b1, 32'd42, 32'h0, 1'b0);
      end
    join
`ifdef SPEICHER_ROUND_ROBIN_EN
    exp_ord = '{1, 0, 1, 0};
`else
    exp_ord = '{1, 1, 0, 0};
`endif
    check_order("held", exp_ord);

    // Random traffic, random RAM latency; data port stays in words 32..63
    lat_fixed = 0;
    fork
      for (int i = 0; i < 30; i++) begin
        g_i = int'($urandom_range(3, 0));
        if (g_i > 0) begin
          repeat (g_i) @(posedge Clock);
          #1;
        end
        instr_req(32'($urandom_range(31, 0)), 1'b0, c_i);
      end
      for (int j = 0; j < 30; j++) begin
        g_d = int'($urandom_range(3, 0));
        if (g_d > 0) begin
          repeat (g_d) @(posedge Clock);
          #1;
        end
        op = int'($urandom_range(3, 0));
        c_d = 32 + int'($urandom_range(31, 0));
        data_req(op == 0 || op == 3, op != 0, 32'(c_d), $urandom, 1'b0);
      end
    join

    repeat (5) @(posedge Clock);
    chk("instr_queue_empty", q_instr.size(), 0);
    chk("data_queue_empty", q_daten.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
